// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit/receive blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } uart_state_e;

  localparam int unsigned DataBitsMin = 5;
  localparam int unsigned DataBitsMax = 8;
  localparam int unsigned StopBitsMin = 1;
  localparam int unsigned StopBitsMax = 2;

  // Callers zero-extend narrower characters; the extra zeros do not change the XOR.
  function automatic logic parity_calc(input logic [DataBitsMax-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read; pushes when full and pops when
// empty are ignored.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] LvlFull = (PtrW+1)'(Depth);
  localparam logic [PtrW:0] LvlOne  = (PtrW+1)'(1);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    level_q;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LvlFull);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PtrOne;
      if (pop_ok)  rptr_q <= rptr_q + PtrOne;
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LvlOne;
        2'b01:   level_q <= level_q - LvlOne;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_ext.sv
// Buffered UART transmitter: configurable data/stop bits, LSB first, 1x baud tick.
// Optional parity bit compiled in with UART_TX_PARITY_EN.
module uart_tx_ext
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          baud_tick_i,
  input  logic                          s_valid_i,
  input  logic [DATA_BITS-1:0]          s_data_i,
  output logic                          s_ready_o,
  input  logic                          parity_en_i,
  input  logic                          parity_odd_i,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          tx_done_o
);

  localparam int unsigned CntW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_BITS - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic LastStop = 1'(STOP_BITS - 1);

  uart_state_e            state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic                   tx_q, tx_d;
  logic                   tx_done_q, tx_done_d;

  logic                   fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0]   fifo_rdata;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_bit_q, par_bit_d;
`else
  logic unused_parity;
  assign unused_parity = parity_en_i ^ parity_odd_i;
`endif

  sync_fifo #(
    .Width (DATA_BITS),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (s_valid_i),
    .wdata_i (s_data_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  assign s_ready_o = !fifo_full;
  assign tx_o      = tx_q;
  assign tx_done_o = tx_done_q;
  assign busy_o    = (state_q != StIdle) || (fifo_level_o != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      StIdle: begin
        if (baud_tick_i && !fifo_empty) begin
          state_d  = StStart;
          fifo_pop = 1'b1;
        end
      end
      StStart: begin
        if (baud_tick_i) state_d = StData;
      end
      StData: begin
        if (baud_tick_i && (bit_cnt_q == LastBit)) begin
`ifdef UART_TX_PARITY_EN
          state_d = par_en_q ? StParity : StStop;
`else
          state_d = StStop;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (baud_tick_i) state_d = StStop;
      end
`endif
      StStop: begin
        if (baud_tick_i && (stop_cnt_q == LastStop)) begin
          // Chain straight into the next start bit when a character is waiting.
          if (!fifo_empty) begin
            state_d  = StStart;
            fifo_pop = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_d       = tx_q;
    tx_done_d  = 1'b0;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
`ifdef UART_TX_PARITY_EN
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
`endif
    case (state_q)
      StIdle: tx_d = 1'b1;
      StStart: begin
        if (baud_tick_i) begin
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (baud_tick_i) begin
          if (bit_cnt_q == LastBit) begin
`ifdef UART_TX_PARITY_EN
            tx_d = par_en_q ? par_bit_q : 1'b1;
`else
            tx_d = 1'b1;
`endif
            stop_cnt_d = 1'b0;
          end else begin
            tx_d      = shift_q[1];
            shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + CntOne;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (baud_tick_i) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
`endif
      StStop: begin
        if (baud_tick_i) begin
          if (stop_cnt_q == LastStop) begin
            tx_done_d = 1'b1;
            tx_d      = 1'b1;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: tx_d = 1'b1;
    endcase

    // Loading a new character overrides whatever the state branch chose.
    if (fifo_pop) begin
      shift_d    = fifo_rdata;
      tx_d       = 1'b0;
      bit_cnt_d  = '0;
      stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_d   = parity_en_i;
      par_bit_d  = parity_calc(DataBitsMax'(fifo_rdata), parity_odd_i);
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else begin
      tx_q       <= tx_d;
      tx_done_q  <= tx_done_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_ext.sv
// Bench for uart_tx_ext: an 8N1 instance and a 7-bit/2-stop instance checked every
// cycle against a frame-level model, plus literal tick sequences.
module tb_uart_tx_ext;

  localparam int Depth = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tick, tick_gen, tick_man, tick_en;
  logic [1:0] s_valid;
  logic [7:0] s_data [2];
  logic       parity_en, parity_odd;
  logic [1:0] s_ready, tx, busy, tx_done;
  logic [2:0] lvl0, lvl1;

  assign tick = tick_gen | tick_man;

  uart_tx_ext #(.DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(Depth)) dut0 (
    .clk_i(clk), .rst_i(rst), .baud_tick_i(tick), .s_valid_i(s_valid[0]),
    .s_data_i(s_data[0]), .s_ready_o(s_ready[0]), .parity_en_i(parity_en),
    .parity_odd_i(parity_odd), .tx_o(tx[0]), .busy_o(busy[0]), .fifo_level_o(lvl0),
    .tx_done_o(tx_done[0])
  );

  uart_tx_ext #(.DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(Depth)) dut1 (
    .clk_i(clk), .rst_i(rst), .baud_tick_i(tick), .s_valid_i(s_valid[1]),
    .s_data_i(s_data[1][6:0]), .s_ready_o(s_ready[1]), .parity_en_i(parity_en),
    .parity_odd_i(parity_odd), .tx_o(tx[1]), .busy_o(busy[1]), .fifo_level_o(lvl1),
    .tx_done_o(tx_done[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int k, input logic [15:0] got,
                     input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s dut%0d: got %0h, want %0h (t=%0t)", nm, k, got, exp, $time);
    end
  endtask

  // Model: a queue of characters and the remaining bits of the frame on the line.
  logic [7:0]  mf [2][Depth];
  int          mf_n [2]    = '{0, 0};
  logic [15:0] fr_bits [2] = '{16'h0, 16'h0};
  int          fr_n [2]    = '{0, 0};
  logic        act [2]     = '{1'b0, 1'b0};
  logic        m_tx [2]    = '{1'b1, 1'b1};
  logic        m_done [2]  = '{1'b0, 1'b0};

  initial begin : model_proc
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        int db, sb, p;
        logic rdy, pb;
        logic [7:0] c;
        db  = (k == 0) ? 8 : 7;
        sb  = (k == 0) ? 1 : 2;
        rdy = (mf_n[k] < Depth);
        if (rst) begin
          mf_n[k] = 0; fr_n[k] = 0; act[k] = 1'b0; m_tx[k] = 1'b1; m_done[k] = 1'b0;
        end else begin
          m_done[k] = 1'b0;
          if (tick) begin
            if (act[k]) begin
              if (fr_n[k] > 0) begin
                m_tx[k]    = fr_bits[k][0];
                fr_bits[k] = fr_bits[k] >> 1;
                fr_n[k]--;
              end else begin
                m_done[k] = 1'b1;
                act[k]    = 1'b0;
              end
            end
            if (!act[k]) begin
              if (mf_n[k] > 0) begin
                c = mf[k][0];
                for (int i = 0; i < Depth - 1; i++) mf[k][i] = mf[k][i+1];
                mf_n[k]--;
                p  = 0;
                pb = 1'b0;
`ifdef UART_TX_PARITY_EN
                if (parity_en) begin
                  p  = 1;
                  pb = (^c) ^ parity_odd;
                end
`endif
                fr_bits[k] = {8'h00, c};
                if (p == 1) fr_bits[k][db] = pb;
                for (int i = 0; i < sb; i++) fr_bits[k][db+p+i] = 1'b1;
                fr_n[k] = db + p + sb;
                m_tx[k] = 1'b0;
                act[k]  = 1'b1;
              end else begin
                m_tx[k] = 1'b1;
              end
            end
          end
          if (s_valid[k] && rdy) begin
            mf[k][mf_n[k]] = (k == 0) ? s_data[k] : (s_data[k] & 8'h7F);
            mf_n[k]++;
          end
        end
      end
    end
  end

  logic        rec_en = 1'b0;
  logic [63:0] rec_bits [2];
  int          rec_n [2];
  int          done_cnt [2];

  initial begin : cmp_proc
    logic tk;
    forever begin
      @(posedge clk);
      tk = tick;
      #2;
      for (int k = 0; k < 2; k++) begin
        chk("tx", k, 16'(tx[k]), 16'(m_tx[k]));
        chk("busy", k, 16'(busy[k]), 16'(act[k] || (mf_n[k] != 0)));
        chk("level", k, 16'((k == 0) ? lvl0 : lvl1), 16'(mf_n[k]));
        chk("s_ready", k, 16'(s_ready[k]), 16'(mf_n[k] < Depth));
        chk("tx_done", k, 16'(tx_done[k]), 16'(m_done[k]));
        if (rec_en) begin
          if (tk && rec_n[k] < 64) begin
            rec_bits[k][rec_n[k]] = tx[k];
            rec_n[k]++;
          end
          if (tx_done[k]) done_cnt[k]++;
        end
      end
    end
  end

  initial begin : tick_proc
    int cnt;
    cnt = 0;
    tick_gen = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_en) begin
        cnt = (cnt + 1) % 4;
        tick_gen = (cnt == 0);
      end else begin
        cnt = 0;
        tick_gen = 1'b0;
      end
    end
  end

  task automatic push(input logic [1:0] which, input logic [7:0] d0, input logic [7:0] d1);
    @(negedge clk);
    s_valid   = which;
    s_data[0] = d0;
    s_data[1] = d1;
    @(negedge clk);
    s_valid = 2'b00;
  endtask

  task automatic start_rec();
    for (int k = 0; k < 2; k++) begin
      rec_bits[k] = '1;
      rec_n[k]    = 0;
      done_cnt[k] = 0;
    end
    rec_en = 1'b1;
  endtask

  task automatic wait_rec(input int n);
    int guard;
    guard = 0;
    while (rec_n[0] < n && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    chk("tick_budget", 0, 16'(rec_n[0] >= n), 16'd1);
  endtask

  initial begin : main_proc
    rst = 1'b1; tick_en = 1'b0; tick_man = 1'b0; s_valid = 2'b00;
    s_data[0] = 8'h00; s_data[1] = 8'h00; parity_en = 1'b0; parity_odd = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 0, 16'(tx[0]), 16'd1);
    chk("rst_ready", 0, 16'(s_ready[0]), 16'd1);
    chk("rst_level", 0, 16'(lvl0), 16'd0);
    chk("rst_busy", 0, 16'(busy[0]), 16'd0);
    rst = 1'b0;

    // Single frames: 0xA5 as 8N1, 0x7F as 7 data + 2 stop.
    push(2'b11, 8'hA5, 8'h7F);
    start_rec();
    tick_en = 1'b1;
    wait_rec(13);
    tick_en = 1'b0;
    rec_en  = 1'b0;
    chk("seq_a5", 0, 16'(rec_bits[0][11:0]), 16'hF4A);
    chk("seq_7f", 1, 16'(rec_bits[1][11:0]), 16'hFFE);
    chk("done_a5", 0, 16'(done_cnt[0]), 16'd1);
    chk("done_7f", 1, 16'(done_cnt[1]), 16'd1);
    chk("idle_busy", 0, 16'(busy[0]), 16'd0);

    // Fill the FIFO, then a fifth push that must be dropped.
    push(2'b11, 8'h55, 8'h55);
    push(2'b11, 8'h0F, 8'h0F);
    push(2'b11, 8'hF0, 8'hF0);
    push(2'b11, 8'h33, 8'h33);
    chk("full_ready", 0, 16'(s_ready[0]), 16'd0);
    chk("full_level", 0, 16'(lvl0), 16'd4);
    push(2'b11, 8'hAA, 8'hAA);
    chk("drop_level", 0, 16'(lvl0), 16'd4);
    start_rec();
    tick_en = 1'b1;
    wait_rec(46);
    tick_en = 1'b0;
    rec_en  = 1'b0;
    chk("b2b_seq", 0, 16'(rec_bits[0][10:0]), 16'h2AA);
    chk("b2b_done", 0, 16'(done_cnt[0]), 16'd4);
    chk("b2b_done", 1, 16'(done_cnt[1]), 16'd4);
    chk("b2b_level", 0, 16'(lvl0), 16'd0);

`ifdef UART_TX_PARITY_EN
    parity_en  = 1'b1;
    parity_odd = 1'b0;
    push(2'b01, 8'h07, 8'h00);
    start_rec();
    tick_en = 1'b1;
    wait_rec(13);
    tick_en = 1'b0;
    rec_en  = 1'b0;
    chk("par_even", 0, 16'(rec_bits[0][11:0]), 16'hE0E);
    chk("par_even_done", 0, 16'(done_cnt[0]), 16'd1);
    parity_odd = 1'b1;
    push(2'b01, 8'h07, 8'h00);
    start_rec();
    tick_en = 1'b1;
    wait_rec(3);
    parity_odd = 1'b0;  // must not affect the frame already popped
    wait_rec(13);
    tick_en = 1'b0;
    rec_en  = 1'b0;
    chk("par_odd", 0, 16'(rec_bits[0][11:0]), 16'hC0E);
    parity_en = 1'b0;
`endif

    // Reset during the 4th data bit with two characters still queued.
    push(2'b01, 8'h3C, 8'h00);
    push(2'b01, 8'h11, 8'h00);
    push(2'b01, 8'h22, 8'h00);
    start_rec();
    tick_en = 1'b1;
    wait_rec(5);
    chk("mid_level", 0, 16'(lvl0), 16'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_tx", 0, 16'(tx[0]), 16'd1);
    chk("rst_mid_level", 0, 16'(lvl0), 16'd0);
    chk("rst_mid_busy", 0, 16'(busy[0]), 16'd0);
    start_rec();
    wait_rec(12);
    tick_en = 1'b0;
    rec_en  = 1'b0;
    chk("rst_quiet", 0, 16'(rec_bits[0][11:0]), 16'hFFF);
    chk("rst_no_done", 0, 16'(done_cnt[0]), 16'd0);

    // Push coinciding with an idle tick is only sent on the next tick.
    repeat (2) @(negedge clk);
    s_valid   = 2'b01;
    s_data[0] = 8'h81;
    tick_man  = 1'b1;
    @(negedge clk);
    s_valid  = 2'b00;
    tick_man = 1'b0;
    chk("same_tick_tx", 0, 16'(tx[0]), 16'd1);
    chk("same_tick_level", 0, 16'(lvl0), 16'd1);
    repeat (3) @(negedge clk);
    tick_man = 1'b1;
    @(negedge clk);
    tick_man = 1'b0;
    chk("next_tick_tx", 0, 16'(tx[0]), 16'd0);
    start_rec();
    tick_en = 1'b1;
    wait_rec(11);
    tick_en = 1'b0;
    rec_en  = 1'b0;
    chk("tail_done", 0, 16'(done_cnt[0]), 16'd1);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
